gate_tester: RTL and testbench

GATE_TESTER -- requirements
Module: gate_tester

---
 rtl/gate_tester.sv | 111 +++++++++++
 tb/tb_gate_tester.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gate_tester.sv
// Exhaustive 2-input gate tester: walks {dut_a,dut_b} through 00..11, holds each
// vector SETTLE_CYCLES cycles, samples dut_y and compares it against a latched truth table.
module gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] observed,
  output logic [3:0] mismatch
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t     state, state_nx;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [3:0] exp_q;
  logic [3:0] mismatch_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !abort) state_nx = SETTLE;
      SETTLE:  if (abort) state_nx = IDLE;
               else if (cnt == 8'(SETTLE_CYCLES - 1)) state_nx = SAMPLE;
      SAMPLE:  if (abort) state_nx = IDLE;
               else if (idx == 2'd3) state_nx = DONE;
               else state_nx = SETTLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Mismatch vector including the bit being captured this cycle, so pass is
  // already valid while done is high.
  always_comb begin
    mismatch_nx      = mismatch;
    mismatch_nx[idx] = dut_y ^ exp_q[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      exp_q    <= '0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
      pass     <= 1'b0;
      observed <= '0;
      mismatch <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            exp_q    <= expected;
            observed <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            dut_a    <= 1'b0;
            dut_b    <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            dut_a <= 1'b0;
            dut_b <= 1'b0;
            pass  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            dut_a <= 1'b0;
            dut_b <= 1'b0;
            pass  <= 1'b0;
          end else begin
            observed[idx] <= dut_y;
            mismatch      <= mismatch_nx;
            if (idx == 2'd3) begin
              pass <= ~|mismatch_nx;
            end else begin
              idx            <= idx + 2'd1;
              {dut_a, dut_b} <= idx + 2'd1;
              cnt            <= '0;
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboarded bench for gate_tester: directed runs against behavioural gate models,
// with a monitor checking each done pulse against queued expectations.
module tb_gate_tester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] expected;
  logic       dut_y;
  logic       dut_a, dut_b, busy, done, pass;
  logic [3:0] observed, mismatch;

  typedef enum int {M_NAND, M_AND, M_ONE} model_t;
  model_t model;

  typedef struct {
    logic [3:0] obs;
    logic [3:0] mm;
    logic       pass;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  int   base;

  gate_tester #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .dut_y(dut_y), .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
    .pass(pass), .observed(observed), .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (model)
      M_NAND:  dut_y = ~(dut_a & dut_b);
      M_AND:   dut_y = dut_a & dut_b;
      default: dut_y = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_edge", 32'(cyc), 32'(e.done_cyc));
        chk("observed", 32'(observed), 32'(e.obs));
        chk("mismatch", 32'(mismatch), 32'(e.mm));
        chk("pass", 32'(pass), 32'(e.pass));
      end
    end
  end

  // Drive start at a negedge; base becomes the cycle number of the accepting edge.
  task automatic launch(input logic [3:0] tt);
    start    = 1'b1;
    expected = tt;
    base     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [3:0] obs, input logic [3:0] mm, input logic p);
    exp_t e;
    e.obs = obs; e.mm = mm; e.pass = p; e.done_cyc = base + 12;
    sb.push_back(e);
  endtask

  task automatic wait_edge(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_obs"}, 32'(observed), 32'd0);
    chk({tag, "_mm"}, 32'(mismatch), 32'd0);
    chk({tag, "_ab"}, 32'({dut_a, dut_b}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0; model = M_NAND;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // NAND run, started on the first edge with reset released.
    rst_n = 1'b1;
    launch(4'b0111);
    push(4'b0111, 4'b0000, 1'b1);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_edge(4);
    chk("vec1_ab", 32'({dut_a, dut_b}), 32'd1);
    wait_edge(7);
    chk("vec2_ab", 32'({dut_a, dut_b}), 32'd2);
    wait_edge(13);
    chk("busy_edge13", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("obs_stable", 32'(observed), 32'b0111);
    chk("pass_stable", 32'(pass), 32'd1);

    // AND run with a stray start at edge 5 and expected changed mid-run.
    model = M_AND;
    launch(4'b0111);
    push(4'b1000, 4'b1111, 1'b0);
    expected = 4'b1000;
    wait_edge(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(13);
    chk("and_busy_edge13", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);

    // Stuck-at-1 gate.
    model = M_ONE;
    launch(4'b0111);
    push(4'b1111, 4'b1000, 1'b0);
    wait_idle("one_idle");
    @(negedge clk);

    // Abort sampled at edge 8 after vectors 0 and 1 were captured.
    model = M_NAND;
    launch(4'b0111);
    wait_edge(7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ab", 32'({dut_a, dut_b}), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_obs", 32'(observed), 32'b0011);
    chk("abort_mm", 32'(mismatch), 32'b0000);
    repeat (15) @(negedge clk);
    chk("abort_obs_held", 32'(observed), 32'b0011);

    // Start blocked by abort in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_blocked", 32'(busy), 32'd0);

    // Reset sampled at edge 4 of a run, then a clean NAND run.
    launch(4'b0111);
    wait_edge(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    launch(4'b0111);
    push(4'b0111, 4'b0000, 1'b1);
    wait_idle("post_rst_idle");
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
